mat4x4_block_seq: RTL and testbench

- Sequencer directly upstream of the 2x2 block multiplier (2x2 x 2x2, Q(BIT_NUM-FRAC_NUM).FRAC_NUM, 1-cycle registered output).
- Streams in two 4x4 fixed-point matrices element-by-element and issues the 8 block products C_ij = A_i0*B_0j + A_i1*B_1j, one per cycle, to the multiplier.
- Accumulates the returned 2x2 partial products and streams the 4x4 result out row-major.

---
 rtl/mat4x4_block_seq.sv | 149 ++++++++++++++
 tb/tb_mat4x4_block_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat4x4_block_seq.sv
// Loads two 4x4 Q-format matrices, issues 8 2x2 block products to an external multiplier, accumulates and streams C row-major.
// Latency: out_valid 10 cycles after the last input beat; backpressure: in_ready low while busy, no output backpressure.
// Optional: MAT_ACC_SAT_EN makes the k=1 block accumulation saturate instead of wrap.
module mat4x4_block_seq #(
    parameter int BIT_NUM  = 18,
    parameter int FRAC_NUM = 9
) (
    input  logic                   clk,
    input  logic                   srst_n,
    input  logic                   in_valid,
    input  logic [BIT_NUM-1:0]     in_data,
    output logic                   in_ready,
    output logic [4*BIT_NUM-1:0]   mul_a,
    output logic [4*BIT_NUM-1:0]   mul_b,
    input  logic [4*BIT_NUM-1:0]   mul_c,
    output logic                   busy,
    output logic                   out_valid,
    output logic [BIT_NUM-1:0]     out_data,
    output logic                   out_last
);

    if (FRAC_NUM < 0 || FRAC_NUM >= BIT_NUM) begin : g_bad_frac
        $error("FRAC_NUM must lie in [0, BIT_NUM)");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [4:0]         ld_cnt;
    logic [2:0]         iss_cnt;
    logic [3:0]         out_cnt;
    logic               cap_vld;
    logic [2:0]         cap_n;
    logic [BIT_NUM-1:0] a_mem [16];
    logic [BIT_NUM-1:0] b_mem [16];
    logic [BIT_NUM-1:0] acc   [16];
    logic               accept;

    assign accept = in_valid & in_ready;

    // Row-major index of slot s (s = {rr,cc}) inside block (r,c): {r, rr, c, cc}.
    function automatic logic [3:0] bidx(input logic r, input logic [1:0] s, input logic c);
        return {r, s[1], c, s[0]};
    endfunction

    function automatic logic [BIT_NUM-1:0] acc_add(input logic [BIT_NUM-1:0] x,
                                                   input logic [BIT_NUM-1:0] y);
        logic [BIT_NUM-1:0] sum;
        sum = x + y;
`ifdef MAT_ACC_SAT_EN
        if (x[BIT_NUM-1] == y[BIT_NUM-1] && sum[BIT_NUM-1] != x[BIT_NUM-1])
            sum = x[BIT_NUM-1] ? {1'b1, {(BIT_NUM-1){1'b0}}} : {1'b0, {(BIT_NUM-1){1'b1}}};
`endif
        return sum;
    endfunction

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        mul_a    = '0;
        mul_b    = '0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && ld_cnt == 5'd31) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                busy = 1'b1;
                // n = {i, j, k}: A block (i,k) times B block (k,j)
                for (int s = 0; s < 4; s++) begin
                    mul_a[s*BIT_NUM +: BIT_NUM] = a_mem[bidx(iss_cnt[2], 2'(s), iss_cnt[0])];
                    mul_b[s*BIT_NUM +: BIT_NUM] = b_mem[bidx(iss_cnt[0], 2'(s), iss_cnt[1])];
                end
                if (iss_cnt == 3'd7) state_d = S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                busy = 1'b1;
                if (out_cnt == 4'd15) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            ld_cnt    <= '0;
            iss_cnt   <= '0;
            out_cnt   <= '0;
            cap_vld   <= 1'b0;
            cap_n     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            for (int e = 0; e < 16; e++) begin
                a_mem[e] <= '0;
                b_mem[e] <= '0;
                acc[e]   <= '0;
            end
        end else begin
            if (accept) begin
                if (ld_cnt[4]) b_mem[ld_cnt[3:0]] <= in_data;
                else           a_mem[ld_cnt[3:0]] <= in_data;
                ld_cnt <= ld_cnt + 5'd1;
            end

            iss_cnt <= (state_q == S_ISSUE) ? iss_cnt + 3'd1 : 3'd0;
            out_cnt <= (state_q == S_OUT) ? out_cnt + 4'd1 : 4'd0;

            // Product for issue n returns one cycle later on mul_c.
            cap_vld <= (state_q == S_ISSUE);
            cap_n   <= iss_cnt;
            if (cap_vld) begin
                for (int s = 0; s < 4; s++) begin
                    if (cap_n[0])
                        acc[bidx(cap_n[2], 2'(s), cap_n[1])] <=
                            acc_add(acc[bidx(cap_n[2], 2'(s), cap_n[1])], mul_c[s*BIT_NUM +: BIT_NUM]);
                    else
                        acc[bidx(cap_n[2], 2'(s), cap_n[1])] <= mul_c[s*BIT_NUM +: BIT_NUM];
                end
            end

            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (state_q == S_WAIT) begin
                out_valid <= 1'b1;
                out_data  <= acc[0];
            end else if (state_q == S_OUT && out_cnt != 4'd15) begin
                out_valid <= 1'b1;
                out_data  <= acc[out_cnt + 4'd1];
                out_last  <= (out_cnt == 4'd14);
            end
        end
    end

endmodule

// File: tb/tb_mat4x4_block_seq.sv
// Bench for mat4x4_block_seq with an ideal registered 2x2 block multiplier and a matrix-level reference model.
module tb_mat4x4_block_seq;
    localparam int BW = 18;
    localparam int FW = 9;

    logic            clk = 1'b0;
    logic            srst_n;
    logic            in_valid;
    logic [BW-1:0]   in_data;
    logic            in_ready;
    logic [4*BW-1:0] mul_a, mul_b, mul_c;
    logic            busy, out_valid, out_last;
    logic [BW-1:0]   out_data;

    int nvec = 0;
    int nerr = 0;

    logic [BW-1:0] ma  [16];
    logic [BW-1:0] mb  [16];
    logic [BW-1:0] res [16];

    mat4x4_block_seq #(.BIT_NUM(BW), .FRAC_NUM(FW)) dut (
        .clk(clk), .srst_n(srst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .busy(busy), .out_valid(out_valid), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Ideal multiplier: C = (A*B) >>> FW per element, truncated to BW, registered.
    function automatic logic [4*BW-1:0] blk_mul(input logic [4*BW-1:0] a, input logic [4*BW-1:0] b);
        logic [4*BW-1:0] c;
        longint s;
        logic signed [BW-1:0] a0, a1, b0, b1;
        c = '0;
        for (int r = 0; r < 2; r++)
            for (int q = 0; q < 2; q++) begin
                a0 = a[(r*2+0)*BW +: BW];
                a1 = a[(r*2+1)*BW +: BW];
                b0 = b[(0*2+q)*BW +: BW];
                b1 = b[(1*2+q)*BW +: BW];
                s = longint'(a0) * longint'(b0) + longint'(a1) * longint'(b1);
                s = s >>> FW;
                c[(r*2+q)*BW +: BW] = s[BW-1:0];
            end
        return c;
    endfunction

    always @(posedge clk) mul_c <= blk_mul(mul_a, mul_b);

    // Reference: C[r][c] = P0 + P1, Pk = (A[r][2k]B[2k][c] + A[r][2k+1]B[2k+1][c]) >>> FW
    function automatic logic [BW-1:0] partial(int r, int c, int k);
        longint s;
        logic signed [BW-1:0] x0, x1, y0, y1;
        x0 = ma[r*4 + 2*k];
        x1 = ma[r*4 + 2*k + 1];
        y0 = mb[(2*k)*4 + c];
        y1 = mb[(2*k+1)*4 + c];
        s = (longint'(x0) * longint'(y0) + longint'(x1) * longint'(y1)) >>> FW;
        return s[BW-1:0];
    endfunction

    task automatic compute_ref();
        logic signed [BW-1:0] p0, p1;
        longint sum;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                p0 = partial(r, c, 0);
                p1 = partial(r, c, 1);
                sum = longint'(p0) + longint'(p1);
`ifdef MAT_ACC_SAT_EN
                if (sum > 131071)  sum = 131071;
                if (sum < -131072) sum = -131072;
`endif
                res[r*4+c] = sum[BW-1:0];
            end
    endtask

    function automatic logic [4*BW-1:0] exp_blk(input bit is_b, input int n);
        logic [4*BW-1:0] v;
        int i, j, k;
        i = n >> 2; j = (n >> 1) & 1; k = n & 1;
        for (int rr = 0; rr < 2; rr++)
            for (int cc = 0; cc < 2; cc++)
                v[(rr*2+cc)*BW +: BW] = is_b ? mb[(2*k+rr)*4 + 2*j+cc] : ma[(2*i+rr)*4 + 2*k+cc];
        return v;
    endfunction

    // Drives 32 beats from negedges; returns at the negedge of cycle L+1.
    task automatic load_mats(input int gap_pct);
        for (int e = 0; e < 32; e++) begin
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = BW'($urandom);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = (e < 16) ? ma[e] : mb[e-16];
            nvec++;
            if (in_ready !== 1'b1) begin
                nerr++;
                $display("FAIL load_ready beat=%0d in_ready=%b required 1", e, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Observes cycles L+1..L+26 at negedges; returns at the negedge of cycle L+26.
    task automatic collect(input bit garbage, input bit chk_issue);
        bit exp_v;
        for (int k = 1; k <= 26; k++) begin
            nvec++;
            if (k <= 25 && (busy !== 1'b1 || in_ready !== 1'b0)) begin
                nerr++;
                $display("FAIL busy_flags k=%0d busy=%b in_ready=%b required 1/0", k, busy, in_ready);
            end else if (k == 26 && (busy !== 1'b0 || in_ready !== 1'b1)) begin
                nerr++;
                $display("FAIL idle_flags busy=%b in_ready=%b required 0/1", busy, in_ready);
            end
            if (chk_issue && k <= 8) begin
                nvec++;
                if (mul_a !== exp_blk(1'b0, k-1) || mul_b !== exp_blk(1'b1, k-1)) begin
                    nerr++;
                    $display("FAIL issue n=%0d mul_a=%h mul_b=%h required %h %h",
                             k-1, mul_a, mul_b, exp_blk(1'b0, k-1), exp_blk(1'b1, k-1));
                end
            end
            exp_v = (k >= 10 && k <= 25);
            nvec++;
            if (out_valid !== exp_v) begin
                nerr++;
                $display("FAIL out_valid k=%0d got=%b required %b", k, out_valid, exp_v);
            end else if (exp_v) begin
                nvec++;
                if (out_data !== res[k-10] || out_last !== (k == 25)) begin
                    nerr++;
                    $display("FAIL out_elem idx=%0d data=%h last=%b required %h %b",
                             k-10, out_data, out_last, res[k-10], (k == 25));
                end
            end
            if (garbage && k <= 25) begin
                in_valid = 1'b1;
                in_data  = BW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (k < 26) @(negedge clk);
        end
    endtask

    task automatic set_ones_half();
        for (int e = 0; e < 16; e++) begin ma[e] = 18'd512; mb[e] = 18'd256; end
    endtask

    task automatic test_reset();
        srst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        nvec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || mul_a !== '0 || mul_b !== '0) begin
            nerr++;
            $display("FAIL reset rdy=%b busy=%b ov=%b ol=%b od=%h ma=%h mb=%h required 1 0 0 0 0 0 0",
                     in_ready, busy, out_valid, out_last, out_data, mul_a, mul_b);
        end
        srst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ones_half();
        set_ones_half();
        compute_ref();
        nvec++;
        if (res[0] !== 18'd1024) begin
            nerr++;
            $display("FAIL ref_ones got=%0d required 1024", res[0]);
        end
        load_mats(0);
        collect(1'b0, 1'b1);
    endtask

    task automatic test_identity();
        for (int e = 0; e < 16; e++) begin
            ma[e] = ((e / 4) == (e % 4)) ? 18'd512 : 18'd0;
            mb[e] = BW'(e + 1);
        end
        compute_ref();
        load_mats(30);
        collect(1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        logic [BW-1:0] want;
`ifdef MAT_ACC_SAT_EN
        want = 18'h1FFFF;
`else
        want = 18'h20000;
`endif
        for (int e = 0; e < 16; e++) begin ma[e] = 18'd32768; mb[e] = 18'd512; end
        compute_ref();
        nvec++;
        if (res[5] !== want) begin
            nerr++;
            $display("FAIL ref_overflow got=%h required %h", res[5], want);
        end
        load_mats(10);
        collect(1'b0, 1'b0);
    endtask

    task automatic test_ignore();
        for (int e = 0; e < 16; e++) begin ma[e] = BW'($urandom); mb[e] = BW'($urandom); end
        compute_ref();
        load_mats(20);
        collect(1'b1, 1'b1);
    endtask

    task automatic test_reset_midop();
        for (int e = 0; e < 16; e++) begin ma[e] = BW'($urandom); mb[e] = BW'($urandom); end
        load_mats(0);
        repeat (3) @(negedge clk);
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        nvec++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL midop_reset in_ready=%b busy=%b required 1/0", in_ready, busy);
        end
        for (int c = 0; c < 30; c++) begin
            nvec++;
            if (out_valid !== 1'b0) begin
                nerr++;
                $display("FAIL midop_no_out cycle=%0d out_valid=%b required 0", c, out_valid);
            end
            @(negedge clk);
        end
        set_ones_half();
        compute_ref();
        load_mats(0);
        collect(1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int e = 0; e < 16; e++) begin ma[e] = BW'($urandom); mb[e] = BW'($urandom); end
        compute_ref();
        load_mats(0);
        collect(1'b0, 1'b0);
        for (int e = 0; e < 16; e++) begin ma[e] = BW'($urandom); mb[e] = BW'($urandom); end
        compute_ref();
        load_mats(0);
        collect(1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_ones_half();
        test_identity();
        test_overflow();
        test_ignore();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
